// File: rtl/sort_job_arbiter.sv
// Round-robin, frame-granular arbiter sharing one sort engine among NUM_REQ AXI-Stream requesters.
// Optional watchdog abort in FEED/DRAIN is compiled in with `define SORT_ARB_TIMEOUT_EN.
module sort_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_tdata,
    input  logic [NUM_REQ-1:0]              req_tvalid,
    output logic [NUM_REQ-1:0]              req_tready,
    input  logic [NUM_REQ-1:0]              req_tlast,
    input  logic [NUM_REQ-1:0]              req_dir,
    output logic [DATA_WIDTH-1:0]           eng_in_tdata,
    output logic                            eng_in_tvalid,
    input  logic                            eng_in_tready,
    output logic                            eng_in_tlast,
    output logic                            eng_sort_dir,
    input  logic [DATA_WIDTH-1:0]           eng_out_tdata,
    input  logic                            eng_out_tvalid,
    output logic                            eng_out_tready,
    input  logic                            eng_out_tlast,
    input  logic [15:0]                     eng_dup_nums,
    output logic [DATA_WIDTH-1:0]           rsp_tdata,
    output logic [NUM_REQ-1:0]              rsp_tvalid,
    input  logic [NUM_REQ-1:0]              rsp_tready,
    output logic                            rsp_tlast,
    output logic [15:0]                     rsp_dup_nums,
    output logic                            job_done,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic [15:0]                     jobs_done,
    output logic                            timeout_err
);

    localparam int GW = $clog2(NUM_REQ);

    // Valid/ready: a beat transfers on a rising edge where valid and ready are both high;
    // valid never depends on ready, and data/last are only meaningful while valid is high.
    typedef enum logic [2:0] {IDLE, ARB, FEED, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   rr_pick;
    int              rr_idx;
    logic            feed_hs;
    logic            drain_hs;
    logic            wd_abort;

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        rr_idx  = 0;
        rr_pick = last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = (int'(last_grant) + k) % NUM_REQ;
            if (req_tvalid[GW'(rr_idx)]) rr_pick = GW'(rr_idx);
        end
    end

    assign feed_hs  = (state == FEED)  && req_tvalid[grant_id] && eng_in_tready;
    assign drain_hs = (state == DRAIN) && eng_out_tvalid && rsp_tready[grant_id];

`ifdef SORT_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_active;

    assign wd_active = ((state == FEED) || (state == DRAIN)) && !feed_hs && !drain_hs;
    assign wd_abort  = wd_active && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = wd_abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          wd_cnt <= '0;
        else if (wd_active) wd_cnt <= wd_cnt + 16'd1;
        else                wd_cnt <= '0;
    end
`else
    assign wd_abort    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        req_tready     = '0;
        eng_in_tdata   = '0;
        eng_in_tvalid  = 1'b0;
        eng_in_tlast   = 1'b0;
        eng_out_tready = 1'b0;
        rsp_tdata      = '0;
        rsp_tvalid     = '0;
        rsp_tlast      = 1'b0;
        case (state)
            IDLE:  if (|req_tvalid) state_nxt = ARB;
            ARB:   state_nxt = (|req_tvalid) ? FEED : IDLE;
            FEED: begin
                eng_in_tdata         = req_tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                eng_in_tvalid        = req_tvalid[grant_id];
                eng_in_tlast         = req_tlast[grant_id];
                req_tready[grant_id] = eng_in_tready;
                if (feed_hs && req_tlast[grant_id]) state_nxt = DRAIN;
            end
            DRAIN: begin
                rsp_tdata            = eng_out_tdata;
                rsp_tlast            = eng_out_tlast;
                rsp_tvalid[grant_id] = eng_out_tvalid;
                eng_out_tready       = rsp_tready[grant_id];
                if (drain_hs && eng_out_tlast) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wd_abort) state_nxt = IDLE;
    end

    assign job_done = (state == DONE);
    assign busy     = (state != IDLE);

    // An aborted job still advances the rotation so a stuck requester cannot monopolise the engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id     <= '0;
            last_grant   <= GW'(NUM_REQ - 1);
            eng_sort_dir <= 1'b0;
            rsp_dup_nums <= '0;
            jobs_done    <= '0;
        end else begin
            if (state == ARB && (|req_tvalid)) begin
                grant_id     <= rr_pick;
                eng_sort_dir <= req_dir[rr_pick];
            end
            if (drain_hs && eng_out_tlast) rsp_dup_nums <= eng_dup_nums;
            if (state == DONE) begin
                jobs_done  <= jobs_done + 16'd1;
                last_grant <= grant_id;
            end
            if (wd_abort) last_grant <= grant_id;
        end
    end

endmodule

// File: tb/tb_sort_job_arbiter.sv
// Scoreboard bench for sort_job_arbiter: requester and engine drivers, negedge monitor, directed jobs.
module tb_sort_job_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam logic [DW-1:0] MASK = 32'hA5A5_0000;

  typedef struct packed { logic [1:0] r; logic [DW-1:0] data; logic last; logic dir; } in_t;
  typedef struct packed { logic [N-1:0] oh; logic [DW-1:0] data; logic last; } rsp_t;
  typedef struct packed { logic [1:0] r; logic [15:0] dup; logic [15:0] cnt; } job_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct packed { logic [15:0] dup; logic mute; } ejob_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*DW-1:0]   req_tdata;
  logic [N-1:0]      req_tvalid, req_tready, req_tlast, req_dir;
  logic [DW-1:0]     eng_in_tdata, eng_out_tdata, rsp_tdata;
  logic              eng_in_tvalid, eng_in_tready, eng_in_tlast, eng_sort_dir;
  logic              eng_out_tvalid, eng_out_tready, eng_out_tlast;
  logic [15:0]       eng_dup_nums, rsp_dup_nums, jobs_done;
  logic [N-1:0]      rsp_tvalid, rsp_tready;
  logic              rsp_tlast, job_done, busy, timeout_err;
  logic [1:0]        grant_id;

  sort_job_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(rst),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .req_tlast(req_tlast), .req_dir(req_dir),
    .eng_in_tdata(eng_in_tdata), .eng_in_tvalid(eng_in_tvalid), .eng_in_tready(eng_in_tready),
    .eng_in_tlast(eng_in_tlast), .eng_sort_dir(eng_sort_dir),
    .eng_out_tdata(eng_out_tdata), .eng_out_tvalid(eng_out_tvalid), .eng_out_tready(eng_out_tready),
    .eng_out_tlast(eng_out_tlast), .eng_dup_nums(eng_dup_nums),
    .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tlast(rsp_tlast),
    .rsp_dup_nums(rsp_dup_nums), .job_done(job_done), .grant_id(grant_id), .busy(busy),
    .jobs_done(jobs_done), .timeout_err(timeout_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  in_t   exp_in_q[$];
  rsp_t  exp_rsp_q[$];
  job_t  exp_job_q[$];
  ejob_t eng_job_q[$];
  beat_t req_q[N][$];
  logic [N-1:0] hold = '0;
  int    beats[N];
  logic  stall_mode = 1'b0;
  logic  rsp_toggle = 1'b0;
  logic [15:0] exp_jobs = '0;
  logic  jobs_pend = 1'b0;
  logic [15:0] pend_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, none expected", name);
  endtask

  // driver tasks
  task automatic send_job(input int r, input logic dir, input int n, input logic [DW-1:0] base,
                          input logic [15:0] dup, input logic mute);
    beat_t b;
    in_t   e;
    rsp_t  s;
    job_t  j;
    ejob_t ej;
    req_dir[r] = dir;
    for (int k = 0; k < n; k++) begin
      b.data = base + DW'(k);
      b.last = (k == n - 1);
      req_q[r].push_back(b);
      e.r = 2'(r); e.data = b.data; e.last = b.last; e.dir = dir;
      exp_in_q.push_back(e);
    end
    ej.dup = dup; ej.mute = mute;
    eng_job_q.push_back(ej);
    if (!mute) begin
      for (int k = n - 1; k >= 0; k--) begin
        s.oh = 4'b0001 << r; s.data = (base + DW'(k)) ^ MASK; s.last = (k == 0);
        exp_rsp_q.push_back(s);
      end
      exp_jobs = exp_jobs + 16'd1;
      j.r = 2'(r); j.dup = dup; j.cnt = exp_jobs;
      exp_job_q.push_back(j);
    end
  endtask

  task automatic do_reset_begin();
    @(posedge clk); #3;
    rst = 1'b1;
    exp_in_q.delete(); exp_rsp_q.delete(); exp_job_q.delete(); eng_job_q.delete();
    exp_jobs = '0;
  endtask

  task automatic do_reset_end();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_jobs_done"}, jobs_done, 0);
    chk({tag, "_job_done"}, job_done, 0);
    chk({tag, "_sort_dir"}, eng_sort_dir, 0);
    chk({tag, "_rsp_dup"}, rsp_dup_nums, 0);
    chk({tag, "_req_tready"}, req_tready, 0);
    chk({tag, "_eng_in_tvalid"}, eng_in_tvalid, 0);
    chk({tag, "_eng_in_tdata"}, eng_in_tdata, 0);
    chk({tag, "_eng_out_tready"}, eng_out_tready, 0);
    chk({tag, "_rsp_tvalid"}, rsp_tvalid, 0);
    chk({tag, "_rsp_tlast"}, rsp_tlast, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_in_q.size() != 0 || exp_rsp_q.size() != 0 || exp_job_q.size() != 0 ||
            busy || jobs_pend) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail({name, "_idle_timeout"});
    @(negedge clk);
  endtask

  // requester driver: pops accepted beats, presents the next one unless held
  initial begin
    logic [N-1:0] hs;
    req_tvalid = '0; req_tdata = '0; req_tlast = '0;
    for (int i = 0; i < N; i++) beats[i] = 0;
    forever begin
      @(negedge clk);
      hs = req_tvalid & req_tready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (rst) req_q[i].delete();
        else if (hs[i] && req_q[i].size() > 0) begin
          void'(req_q[i].pop_front());
          beats[i]++;
        end
        if (!rst && !hold[i] && req_q[i].size() > 0) begin
          req_tvalid[i] = 1'b1;
          req_tdata[i*DW +: DW] = req_q[i][0].data;
          req_tlast[i] = req_q[i][0].last;
        end else begin
          req_tvalid[i] = 1'b0;
          req_tdata[i*DW +: DW] = '0;
          req_tlast[i] = 1'b0;
        end
      end
    end
  end

  // engine model: collects a frame, replies with it reversed and masked, dup on the last beat only
  initial begin
    logic [DW-1:0] job_buf[$];
    beat_t reply_q[$];
    beat_t rb;
    ejob_t ej;
    logic [15:0] cur_dup;
    logic in_hs, in_l, out_hs, tog;
    logic [DW-1:0] in_d;
    int cyc;
    cur_dup = '0; tog = 1'b0; cyc = 0;
    eng_in_tready = 1'b0; eng_out_tvalid = 1'b0; eng_out_tdata = '0;
    eng_out_tlast = 1'b0; eng_dup_nums = '0; rsp_tready = '0;
    forever begin
      @(negedge clk);
      in_hs = eng_in_tvalid && eng_in_tready;
      in_d = eng_in_tdata;
      in_l = eng_in_tlast;
      out_hs = eng_out_tvalid && eng_out_tready;
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        job_buf.delete();
        reply_q.delete();
      end else begin
        if (out_hs && reply_q.size() > 0) void'(reply_q.pop_front());
        if (in_hs) begin
          job_buf.push_back(in_d);
          if (in_l) begin
            ej.dup = 16'h0; ej.mute = 1'b1;
            if (eng_job_q.size() > 0) ej = eng_job_q.pop_front();
            cur_dup = ej.dup;
            if (!ej.mute)
              for (int k = job_buf.size() - 1; k >= 0; k--) begin
                rb.data = job_buf[k] ^ MASK;
                rb.last = (k == 0);
                reply_q.push_back(rb);
              end
            job_buf.delete();
          end
        end
      end
      eng_in_tready = !rst && (!stall_mode || (cyc % 3 != 0));
      tog = ~tog;
      rsp_tready = (!rsp_toggle || tog) ? '1 : '0;
      if (!rst && reply_q.size() > 0) begin
        eng_out_tvalid = 1'b1;
        eng_out_tdata = reply_q[0].data;
        eng_out_tlast = reply_q[0].last;
        eng_dup_nums = reply_q[0].last ? cur_dup : 16'hDEAD;
      end else begin
        eng_out_tvalid = 1'b0; eng_out_tdata = '0; eng_out_tlast = 1'b0; eng_dup_nums = 16'hDEAD;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic drain_act;
    logic [1:0] drain_r;
    in_t  e;
    rsp_t s;
    job_t j;
    drain_act = 1'b0; drain_r = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        drain_act = 1'b0;
        jobs_pend = 1'b0;
      end else begin
        if (req_tready != '0) begin
          if (exp_in_q.size() == 0) fail("req_tready_unexpected");
          else chk("req_tready_onehot", req_tready, 4'b0001 << exp_in_q[0].r);
        end
        chk("eng_out_tready", eng_out_tready, drain_act ? rsp_tready[drain_r] : 1'b0);
        if (eng_in_tvalid && eng_in_tready) begin
          if (exp_in_q.size() == 0) fail("eng_in_unexpected");
          else begin
            e = exp_in_q.pop_front();
            chk("eng_in_tdata", eng_in_tdata, e.data);
            chk("eng_in_tlast", eng_in_tlast, e.last);
            chk("eng_sort_dir", eng_sort_dir, e.dir);
            chk("grant_id_feed", grant_id, e.r);
            if (e.last) begin
              drain_act = 1'b1;
              drain_r = e.r;
            end
          end
        end
        if (|(rsp_tvalid & rsp_tready)) begin
          if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
          else begin
            s = exp_rsp_q.pop_front();
            chk("rsp_tvalid", rsp_tvalid, s.oh);
            chk("rsp_tdata", rsp_tdata, s.data);
            chk("rsp_tlast", rsp_tlast, s.last);
          end
          if (rsp_tlast) drain_act = 1'b0;
        end
        if (jobs_pend) begin
          chk("jobs_done", jobs_done, pend_cnt);
          jobs_pend = 1'b0;
        end
        if (job_done) begin
          if (exp_job_q.size() == 0) fail("job_done_unexpected");
          else begin
            j = exp_job_q.pop_front();
            chk("grant_id_done", grant_id, j.r);
            chk("rsp_dup_nums", rsp_dup_nums, j.dup);
            pend_cnt = j.cnt;
            jobs_pend = 1'b1;
          end
        end
`ifndef SORT_ARB_TIMEOUT_EN
        chk("timeout_err_tied", timeout_err, 0);
`endif
        if (timeout_err) drain_act = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "global timeout");
  end

  // directed test sequence
  initial begin
    int lat;
    int b0;
    logic seen;
    rst = 1'b1;
    req_dir = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk); #3 rst = 1'b0;

    // single 4-beat ascending job on req0, grant latency 2 cycles from tvalid
    send_job(0, 1'b1, 4, 32'h100, 16'd2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (req_tvalid[0]) seen = 1'b1;
    end
    lat = 0;
    while (!req_tready[0] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("grant_latency", lat, 2);
    chk("t1_sort_dir", eng_sort_dir, 1);
    wait_idle("t1");
    chk("t1_jobs_done", jobs_done, 1);

    // all four requesters from reset: grants 0,1,2,3,0 with a stalling engine input
    do_reset_begin();
    do_reset_end();
    stall_mode = 1'b1;
    send_job(0, 1'b1, 2, 32'h200, 16'd0, 1'b0);
    send_job(1, 1'b0, 2, 32'h210, 16'd1, 1'b0);
    send_job(2, 1'b1, 3, 32'h220, 16'd2, 1'b0);
    send_job(3, 1'b0, 2, 32'h230, 16'd0, 1'b0);
    send_job(0, 1'b1, 2, 32'h240, 16'd5, 1'b0);
    wait_idle("t2");
    chk("t2_jobs_done", jobs_done, 5);
    stall_mode = 1'b0;

    // req2 stalls mid-frame while req1 waits; grant must stay on 2
    send_job(1, 1'b0, 2, 32'h300, 16'd0, 1'b0);
    wait_idle("t3a");
    send_job(2, 1'b1, 4, 32'h310, 16'd1, 1'b0);
    send_job(1, 1'b0, 3, 32'h320, 16'd0, 1'b0);
    b0 = beats[2];
    lat = 0;
    while (beats[2] - b0 < 2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    hold[2] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t3_hold_grant", grant_id, 2);
    chk("t3_hold_busy", busy, 1);
    hold[2] = 1'b0;
    wait_idle("t3");
    chk("t3_jobs_done", jobs_done, 8);

    // response back-pressure toggling during DRAIN
    rsp_toggle = 1'b1;
    send_job(3, 1'b1, 4, 32'h400, 16'd3, 1'b0);
    wait_idle("t4");
    chk("t4_rsp_dup", rsp_dup_nums, 3);
    rsp_toggle = 1'b0;

    // reset during FEED drops the frame; rotation restarts at requester 0
    send_job(1, 1'b0, 6, 32'h500, 16'd7, 1'b0);
    b0 = beats[1];
    lat = 0;
    while (beats[1] - b0 < 2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    do_reset_begin();
    #1 reset_checks("midjob");
    do_reset_end();
    send_job(0, 1'b1, 2, 32'h610, 16'd1, 1'b0);
    send_job(3, 1'b0, 2, 32'h600, 16'd2, 1'b0);
    wait_idle("t5");
    chk("t5_jobs_done", jobs_done, 2);

`ifdef SORT_ARB_TIMEOUT_EN
    // engine never replies: watchdog aborts 16 cycles after the last handshake
    send_job(2, 1'b1, 3, 32'h700, 16'd0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (eng_in_tvalid && eng_in_tready && eng_in_tlast) seen = 1'b1;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!timeout_err && lat < 40);
    chk("t6_timeout_delay", lat, 16);
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_jobs_done", jobs_done, 2);
    wait_idle("t6");
`endif

    chk("queues_empty", exp_in_q.size() + exp_rsp_q.size() + exp_job_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
